// File: rtl/div.sv
// Iterative radix-2 restoring divider, signed or unsigned.
// Result is {remainder, quotient}: the upper half loads HI, the lower half loads LO.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               annul,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   amag, bmag_in;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   rem_n, quo_n;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // One restoring step plus final sign fix-up of the step's outputs
  always_comb begin
    neg_a   = sign & a[WIDTH-1];
    neg_b   = sign & b[WIDTH-1];
    amag    = neg_a ? -a : a;
    bmag_in = neg_b ? -b : b;
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, bmag_q};
    rem_n   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_n   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    q_fix   = (sa_q ^ sb_q) ? -quo_n : quo_n;
    r_fix   = sa_q ? -rem_n : rem_n;
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bmag_d  = bmag_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          sa_d   = neg_a;
          sb_d   = neg_b;
          bmag_d = bmag_in;
          quo_d  = amag;
          rem_d  = '0;
          cnt_d  = '0;
          if (b == '0) begin
            state_d = DONE;
            res_d   = {a, {WIDTH{1'b1}}};
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
            res_d   = {r_fix, q_fix};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bmag_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bmag_q  <= bmag_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign ready  = (state_q == DONE);
  assign result = res_q;

endmodule
